// File: rtl/day_pkg.sv
// Shared definitions for the date-scan controller.
//   state_e  : controller states (COLLECT, FEED, DRAIN, REPORT)
//   TERM_DEF : default string terminator byte
//   calc_lw  : width able to hold 0..DEPTH (length / 1-based byte index)
//   calc_aw  : address width of the DEPTH-entry string buffer
package day_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FEED    = 2'd1,
    DRAIN   = 2'd2,
    REPORT  = 2'd3
  } state_e;

  localparam logic [7:0] TERM_DEF = 8'h00;

  function automatic int calc_lw(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/day_scan_buf.sv
// String buffer: DEPTH x 8 register file, one write port, one
// asynchronous read port. The data array carries no reset; only the
// controller's length register decides which entries are meaningful.
//   clk     : clock, rising edge
//   wr_en   : write strobe
//   wr_addr : write index (current string length)
//   wr_data : byte to store
//   rd_addr : read index (feed pointer)
//   rd_data : byte at rd_addr
module day_scan_buf
  import day_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = calc_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/day_scan_ctrl.sv
// Date-scan controller. Buffers one terminated string, replays it
// back-to-back into the external date recognizer, counts rising edges of
// the recognizer hit and returns a per-string result record.
//   clk       : clock, rising edge
//   reset     : asynchronous, active-low
//   in_valid / in_data / in_ready : upstream byte stream
//   rec_char  : byte to the recognizer (0 outside FEED)
//   rec_clr   : recognizer clear, low only in FEED and DRAIN
//   rec_hit   : recognizer output for all bytes clocked in so far
//   res_valid / res_ready : result handshake
//   res_count : dates found (saturating)
//   res_first : 1-based index of the byte completing the first date, 0 if none
//   res_len   : number of bytes replayed
//   res_ovf   : string was truncated at DEPTH bytes
module day_scan_ctrl
  import day_pkg::*;
#(
  parameter int         DEPTH = 32,
  parameter int         CNT_W = 8,
  parameter logic [7:0] TERM  = TERM_DEF,
  localparam int        LW    = calc_lw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [7:0]       rec_char,
  output logic             rec_clr,
  input  logic             rec_hit,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [LW-1:0]    res_first,
  output logic [LW-1:0]    res_len,
  output logic             res_ovf
);

  localparam int AW = calc_aw(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LW-1:0]     first_q, first_d;
  logic              ovf_q, ovf_d;
  logic              prev_q, prev_d;
  logic              in_ready_q, in_ready_d;
  logic              rec_clr_q, rec_clr_d;
  logic              res_valid_q, res_valid_d;

  logic              wr_en;
  logic              smp_en;
  logic [LW-1:0]     smp_idx;
  logic [7:0]        rd_data;

  day_scan_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (len_q[AW-1:0]),
    .wr_data (in_data),
    .rd_addr (ptr_q[AW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    ovf_d   = ovf_q;
    prev_d  = prev_q;
    wr_en   = 1'b0;
    smp_en  = 1'b0;
    smp_idx = '0;

    case (state_q)
      COLLECT: begin
        if (in_valid && in_ready_q) begin
          if (in_data == TERM) begin
            // An empty string skips replay entirely.
            if (len_q == '0) begin
              state_d = REPORT;
            end else begin
              state_d = FEED;
              ptr_d   = '0;
              prev_d  = 1'b0;
            end
          end else begin
            wr_en = 1'b1;
            len_d = len_q + LW'(1);
            // Buffer full: truncate and replay; the terminator is left
            // in the stream for the next string.
            if (len_q == LW'(DEPTH - 1)) begin
              ovf_d   = 1'b1;
              state_d = FEED;
              ptr_d   = '0;
              prev_d  = 1'b0;
            end
          end
        end
      end

      FEED: begin
        // The hit seen in cycle k reflects bytes 1..k, so nothing is
        // sampled in the very first replay cycle.
        smp_en  = (ptr_q != '0);
        smp_idx = ptr_q;
        ptr_d   = ptr_q + LW'(1);
        if (ptr_q == len_q - LW'(1)) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        smp_en  = 1'b1;
        smp_idx = len_q;
        state_d = REPORT;
      end

      REPORT: begin
        if (res_ready) begin
          state_d = COLLECT;
          len_d   = '0;
          cnt_d   = '0;
          first_d = '0;
          ovf_d   = 1'b0;
        end
      end

      default: state_d = COLLECT;
    endcase

    if (smp_en) begin
      if (rec_hit && !prev_q) begin
        cnt_d = sat_inc(cnt_q);
        if (cnt_q == '0) begin
          first_d = smp_idx;
        end
      end
      prev_d = rec_hit;
    end
  end

  assign in_ready_d  = (state_d == COLLECT);
  assign rec_clr_d   = !((state_d == FEED) || (state_d == DRAIN));
  assign res_valid_d = (state_d == REPORT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      len_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      first_q     <= '0;
      ovf_q       <= 1'b0;
      prev_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      rec_clr_q   <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      ovf_q       <= ovf_d;
      prev_q      <= prev_d;
      in_ready_q  <= in_ready_d;
      rec_clr_q   <= rec_clr_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign rec_clr   = rec_clr_q;
  assign res_valid = res_valid_q;
  assign rec_char  = (state_q == FEED) ? rd_data : 8'h00;
  assign res_count = cnt_q;
  assign res_first = first_q;
  assign res_len   = len_q;
  assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_day_scan_ctrl.sv
// Bench for day_scan_ctrl with a small behavioural date recognizer:
// digits, separator (. - /), digits, separator, digits.
module tb_day_scan_ctrl;
  import day_pkg::*;

  localparam int DEPTH = 32;
  localparam int CNT_W = 8;
  localparam int LW    = calc_lw(DEPTH);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready;
  logic [7:0]       rec_char;
  logic             rec_clr;
  logic             rec_hit;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [CNT_W-1:0] res_count;
  logic [LW-1:0]    res_first;
  logic [LW-1:0]    res_len;
  logic             res_ovf;

  day_scan_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TERM(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rec_char  (rec_char),
    .rec_clr   (rec_clr),
    .rec_hit   (rec_hit),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_first (res_first),
    .res_len   (res_len),
    .res_ovf   (res_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Recognizer model: state 5 means the bytes so far end in a date.
  function automatic int rec_next(input int s, input logic [7:0] c);
    logic dig, sep;
    dig = (c >= 8'h30) && (c <= 8'h39);
    sep = (c == 8'h2E) || (c == 8'h2D) || (c == 8'h2F);
    if (dig) begin
      if (s <= 1) return 1;
      if (s <= 3) return 3;
      return 5;
    end
    if (sep) begin
      if (s == 1) return 2;
      if (s == 3 || s == 5) return 4;
    end
    return 0;
  endfunction

  int rs = 0;
  always @(posedge clk) begin
    if (rec_clr) rs <= 0;
    else         rs <= rec_next(rs, rec_char);
  end
  assign rec_hit = (rs == 5);

  int feed_cycles = 0;
  int feed_sum    = 0;
  always @(negedge clk) begin
    if (!rec_clr) begin
      feed_cycles = feed_cycles + 1;
      feed_sum    = feed_sum + int'(rec_char);
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int hs_cyc   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = b;
    hs_cyc   = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_str(input string s, input logic add_term);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    if (add_term) send_byte(8'h00);
  endtask

  task automatic wait_result(output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_seen", int'(res_valid), 1);
    lat = cyc - hs_cyc;
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_in_ready", int'(in_ready), 1);
    chk("post_hs_res_valid", int'(res_valid), 0);
  endtask

  task automatic clear_mon();
    feed_cycles = 0;
    feed_sum    = 0;
  endtask

  function automatic int str_sum(input string s);
    int t;
    t = 0;
    for (int i = 0; i < s.len(); i++) t += int'(s[i]);
    return t;
  endfunction

  int lat;
  string s;

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_rec_clr", int'(rec_clr), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_rec_char", int'(rec_char), 0);
    chk("rst_res_len", int'(res_len), 0);
    chk("rst_res_count", int'(res_count), 0);
    chk("rst_res_first", int'(res_first), 0);
    chk("rst_res_ovf", int'(res_ovf), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Single date, latency check.
    s = "2021.10.26";
    clear_mon();
    send_str(s, 1'b1);
    wait_result(lat);
    chk("s1_latency", lat, 12);
    chk("s1_len", int'(res_len), 10);
    chk("s1_count", int'(res_count), 1);
    chk("s1_first", int'(res_first), 9);
    chk("s1_ovf", int'(res_ovf), 0);
    chk("s1_feed_cycles", feed_cycles, 11);
    chk("s1_feed_sum", feed_sum, str_sum(s));
    accept_result();

    // Two dates.
    s = "1-2-3 4-5-6";
    clear_mon();
    send_str(s, 1'b1);
    wait_result(lat);
    chk("s2_latency", lat, 13);
    chk("s2_count", int'(res_count), 2);
    chk("s2_first", int'(res_first), 5);
    chk("s2_len", int'(res_len), 11);
    chk("s2_feed_sum", feed_sum, str_sum(s));
    accept_result();

    // Lone terminator.
    clear_mon();
    send_byte(8'h00);
    wait_result(lat);
    chk("nul_latency", lat, 1);
    chk("nul_count", int'(res_count), 0);
    chk("nul_first", int'(res_first), 0);
    chk("nul_len", int'(res_len), 0);
    chk("nul_ovf", int'(res_ovf), 0);
    chk("nul_no_feed", feed_cycles, 0);
    accept_result();

    // 40 x '9' + NUL: truncation at DEPTH, remainder forms the next string.
    clear_mon();
    for (int i = 0; i < DEPTH; i++) send_byte(8'h39);
    chk("ovf_in_ready_low", int'(in_ready), 0);
    wait_result(lat);
    chk("ovf_latency", lat, DEPTH + 2);
    chk("ovf_len", int'(res_len), DEPTH);
    chk("ovf_flag", int'(res_ovf), 1);
    chk("ovf_count", int'(res_count), 0);
    chk("ovf_feed_sum", feed_sum, DEPTH * 57);
    accept_result();
    clear_mon();
    for (int i = 0; i < 8; i++) send_byte(8'h39);
    send_byte(8'h00);
    wait_result(lat);
    chk("rest_len", int'(res_len), 8);
    chk("rest_ovf", int'(res_ovf), 0);
    chk("rest_count", int'(res_count), 0);
    accept_result();

    // Backpressure on the result.
    send_str("5/7/4", 1'b1);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", int'(res_valid), 1);
      chk("hold_count", int'(res_count), 1);
      chk("hold_first", int'(res_first), 5);
      chk("hold_len", int'(res_len), 5);
      chk("hold_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    chk("hold_in_ready_at_hs", int'(in_ready), 0);
    accept_result();

    // Reset in the middle of replay.
    send_str("12.03.15", 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_feed_clr_low", int'(rec_clr), 0);
    reset = 1'b0;
    #1;
    chk("abort_rec_clr", int'(rec_clr), 1);
    chk("abort_res_valid", int'(res_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_result", int'(res_valid), 0);
    chk("abort_len_cleared", int'(res_len), 0);
    send_str("3.4.5", 1'b1);
    wait_result(lat);
    chk("after_abort_count", int'(res_count), 1);
    chk("after_abort_first", int'(res_first), 5);
    chk("after_abort_len", int'(res_len), 5);
    accept_result();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
